// File: rtl/board_ram_arbiter.sv
// board_ram_arbiter: shares the single-port 10x10 board RAM between the
// VGA renderer (display, strict priority) and the game path, with a
// starvation guard that forces a game grant after STARVE_MAX denials.
// Read data is returned on a fixed 2-cycle pipeline.
// Ports:
//   clk, rst_n                      : vga_clk, async active-low reset
//   disp_req/addr -> disp_rvalid/rdata/miss : renderer read port
//   game_req/we/addr/wdata -> game_gnt, game_rvalid/rdata : game port
//   ram_en/we/addr/wdata, ram_rdata : board RAM (1-cycle read latency)
// Optional: `define BOARD_ARB_STATS_EN adds stats_clr, stall_cnt and
// force_cnt (16-bit saturating event counters).
module board_ram_arbiter #(
  parameter int ADDR_W     = 7,
  parameter int DATA_W     = 2,
  parameter int STARVE_MAX = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic              disp_rvalid,
  output logic [DATA_W-1:0] disp_rdata,
  output logic              disp_miss,
  input  logic              game_req,
  input  logic              game_we,
  input  logic [ADDR_W-1:0] game_addr,
  input  logic [DATA_W-1:0] game_wdata,
  output logic              game_gnt,
  output logic              game_rvalid,
  output logic [DATA_W-1:0] game_rdata,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
`ifdef BOARD_ARB_STATS_EN
  ,
  input  logic              stats_clr,
  output logic [15:0]       stall_cnt,
  output logic [15:0]       force_cnt
`endif
);

  typedef enum logic [1:0] {
    OWN_IDLE,
    OWN_DISP,
    OWN_GAME
  } owner_e;

  localparam int CW =
    (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
  localparam logic [CW-1:0] SMAX = CW'(STARVE_MAX);

  owner_e          owner;
  logic            force_w;
  logic [CW-1:0]   wait_cnt_q, wait_cnt_d;

  logic            s1_dreq_q;
  logic            s1_dgnt_q;
  logic            s1_grd_q;

  logic              disp_rvalid_q;
  logic [DATA_W-1:0] disp_rdata_q;
  logic              disp_miss_q;
  logic [DATA_W-1:0] held_q;
  logic              game_rvalid_q;
  logic [DATA_W-1:0] game_rdata_q;

  assign force_w = (STARVE_MAX != 0) &&
                   (wait_cnt_q == SMAX) && game_req;

  // Starvation override beats display priority.
  always_comb begin
    owner = OWN_IDLE;
    priority case (1'b1)
      force_w:  owner = OWN_GAME;
      disp_req: owner = OWN_DISP;
      game_req: owner = OWN_GAME;
      default:  owner = OWN_IDLE;
    endcase
  end

  always_comb begin
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    unique case (owner)
      OWN_DISP: begin
        ram_en   = 1'b1;
        ram_addr = disp_addr;
      end
      OWN_GAME: begin
        ram_en    = 1'b1;
        ram_we    = game_we;
        ram_addr  = game_addr;
        ram_wdata = game_wdata;
      end
      default: begin
        ram_en = 1'b0;
      end
    endcase
  end

  assign game_gnt = (owner == OWN_GAME);

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (!game_req || game_gnt)
      wait_cnt_d = '0;
    else if (wait_cnt_q != SMAX)
      wait_cnt_d = wait_cnt_q + CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt_q    <= '0;
      s1_dreq_q     <= 1'b0;
      s1_dgnt_q     <= 1'b0;
      s1_grd_q      <= 1'b0;
      disp_rvalid_q <= 1'b0;
      disp_rdata_q  <= '0;
      disp_miss_q   <= 1'b0;
      held_q        <= '0;
      game_rvalid_q <= 1'b0;
      game_rdata_q  <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      s1_dreq_q  <= disp_req;
      s1_dgnt_q  <= (owner == OWN_DISP);
      s1_grd_q   <= game_gnt && !game_we;

      disp_rvalid_q <= s1_dreq_q;
      // A requested-but-ungranted display read can only be a forced
      // pre-emption; replay the last good cell value.
      disp_miss_q   <= s1_dreq_q && !s1_dgnt_q;
      if (s1_dgnt_q) begin
        disp_rdata_q <= ram_rdata;
        held_q       <= ram_rdata;
      end else if (s1_dreq_q) begin
        disp_rdata_q <= held_q;
      end

      game_rvalid_q <= s1_grd_q;
      if (s1_grd_q)
        game_rdata_q <= ram_rdata;
    end
  end

  assign disp_rvalid = disp_rvalid_q;
  assign disp_rdata  = disp_rdata_q;
  assign disp_miss   = disp_miss_q;
  assign game_rvalid = game_rvalid_q;
  assign game_rdata  = game_rdata_q;

`ifdef BOARD_ARB_STATS_EN
  logic [15:0] stall_cnt_q;
  logic [15:0] force_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      force_cnt_q <= '0;
    end else if (stats_clr) begin
      stall_cnt_q <= '0;
      force_cnt_q <= '0;
    end else begin
      if (game_req && !game_gnt && stall_cnt_q != 16'hFFFF)
        stall_cnt_q <= stall_cnt_q + 16'd1;
      if (force_w && force_cnt_q != 16'hFFFF)
        force_cnt_q <= force_cnt_q + 16'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign force_cnt = force_cnt_q;
`endif

endmodule

// File: tb/tb_board_ram_arbiter.sv
// tb_board_ram_arbiter: self-checking bench for board_ram_arbiter with a
// behavioural RAM and an abstract arbitration/latency reference model.
module tb_board_ram_arbiter;

  localparam int AW = 7;
  localparam int DW = 2;
  localparam int SM = 16;

  logic          clk;
  logic          rst_n;
  logic          disp_req;
  logic [AW-1:0] disp_addr;
  logic          disp_rvalid;
  logic [DW-1:0] disp_rdata;
  logic          disp_miss;
  logic          game_req;
  logic          game_we;
  logic [AW-1:0] game_addr;
  logic [DW-1:0] game_wdata;
  logic          game_gnt;
  logic          game_rvalid;
  logic [DW-1:0] game_rdata;
  logic          ram_en;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata = '0;
`ifdef BOARD_ARB_STATS_EN
  logic          stats_clr;
  logic [15:0]   stall_cnt;
  logic [15:0]   force_cnt;
`endif

  board_ram_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SM)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .disp_req(disp_req), .disp_addr(disp_addr),
    .disp_rvalid(disp_rvalid), .disp_rdata(disp_rdata),
    .disp_miss(disp_miss),
    .game_req(game_req), .game_we(game_we),
    .game_addr(game_addr), .game_wdata(game_wdata),
    .game_gnt(game_gnt), .game_rvalid(game_rvalid),
    .game_rdata(game_rdata),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
`ifdef BOARD_ARB_STATS_EN
    ,
    .stats_clr(stats_clr), .stall_cnt(stall_cnt),
    .force_cnt(force_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Physical single-port RAM, 1-cycle read latency.
  logic [DW-1:0] mem [0:127];
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      ram_rdata <= mem[ram_addr];
    end
  end

  // Reference model state.
  typedef struct packed {
    logic          dv;
    logic [DW-1:0] dd;
    logic          dm;
    logic          gv;
    logic [DW-1:0] gd;
  } rec_t;

  logic [DW-1:0] shadow [0:127];
  int            starve;
  logic [DW-1:0] last_good;
  logic [DW-1:0] exp_dd, exp_gd;
  rec_t          pend;
  int            m_stall, m_force;

  logic [11:0]   exp_ram, obs_ram;
  logic [6:0]    exp_out, obs_out;
  logic          obs_gnt;

  int n_chk = 0;
  int n_fail = 0;

  task automatic model_clear();
    starve    = 0;
    last_good = '0;
    exp_dd    = '0;
    exp_gd    = '0;
    pend      = '0;
  endtask

  // One cycle: drive, predict owner and RAM drive, advance the clock,
  // then capture the outputs due for the previous cycle's request.
  task automatic step(input logic dr, input logic [AW-1:0] da,
                      input logic gr, input logic gw,
                      input logic [AW-1:0] ga,
                      input logic [DW-1:0] gd);
    int   own;
    logic frc;
    rec_t nd;
    @(negedge clk);
    disp_req   = dr;
    disp_addr  = da;
    game_req   = gr;
    game_we    = gw;
    game_addr  = ga;
    game_wdata = gd;
    #1;
    frc = gr && (starve == SM);
    if (frc)      own = 2;
    else if (dr)  own = 1;
    else if (gr)  own = 2;
    else          own = 0;
    exp_ram = {own == 2, own != 0, own == 2 && gw,
               (own == 1) ? da : ((own == 2) ? ga : 7'd0),
               (own == 2 && gw) ? gd : 2'd0};
    obs_ram = {game_gnt, ram_en, ram_we,
               (own != 0) ? ram_addr : 7'd0,
               (own == 2 && gw) ? ram_wdata : 2'd0};
    obs_gnt = game_gnt;
    nd = '0;
    nd.dv = dr;
    if (dr) begin
      if (own == 1) begin
        nd.dd = shadow[da];
        last_good = shadow[da];
      end else begin
        nd.dd = last_good;
        nd.dm = 1'b1;
      end
    end
    if (own == 2 && !gw) begin
      nd.gv = 1'b1;
      nd.gd = shadow[ga];
    end
    if (own == 2 && gw) shadow[ga] = gd;
    if (gr && own != 2) begin
      starve = (starve < SM) ? starve + 1 : SM;
      m_stall++;
    end else begin
      starve = 0;
    end
    if (frc) m_force++;
    @(posedge clk);
    #1;
    if (pend.dv) exp_dd = pend.dd;
    if (pend.gv) exp_gd = pend.gd;
    exp_out = {pend.dv, exp_dd, pend.dv & pend.dm,
               pend.gv, exp_gd};
    obs_out = {disp_rvalid, disp_rdata, disp_miss,
               game_rvalid, game_rdata};
    pend = nd;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    disp_req = 0; disp_addr = 0;
    game_req = 0; game_we = 0; game_addr = 0; game_wdata = 0;
`ifdef BOARD_ARB_STATS_EN
    stats_clr = 0;
`endif
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    n_chk++;
    if ({disp_rvalid, disp_rdata, disp_miss, game_rvalid,
         game_rdata, game_gnt, ram_en, ram_we} !== 10'd0) begin
      n_fail++;
      $display("FAIL reset_state obs=%b exp=0",
        {disp_rvalid, disp_rdata, disp_miss, game_rvalid,
         game_rdata, game_gnt, ram_en, ram_we});
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single_read();
    int pulses = 0;
    mem[5] = 2'b10;
    shadow[5] = 2'b10;
    step(1, 5, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0, 0, 0);
      if (disp_rvalid) pulses++;
      n_chk++;
      if (obs_out !== exp_out) begin
        n_fail++;
        $display("FAIL single_read obs=%b exp=%b", obs_out, exp_out);
      end
      if (i == 0) begin
        n_chk++;
        if ({disp_rvalid, disp_rdata, disp_miss} !== 4'b1100) begin
          n_fail++;
          $display("FAIL single_read_n2 obs=%b exp=1100",
            {disp_rvalid, disp_rdata, disp_miss});
        end
      end
    end
    n_chk++;
    if (pulses != 1) begin
      n_fail++;
      $display("FAIL single_read_pulses obs=%0d exp=1", pulses);
    end
  endtask

  task automatic test_write_then_read();
    step(0, 0, 1, 1, 3, 2'b11);
    n_chk++;
    if (obs_ram !== exp_ram || obs_ram[10:9] !== 2'b11) begin
      n_fail++;
      $display("FAIL wr_grant obs=%h exp=%h", obs_ram, exp_ram);
    end
    step(1, 3, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    n_chk++;
    if ({disp_rvalid, disp_rdata, game_rvalid} !== 4'b1110 ||
        obs_out !== exp_out) begin
      n_fail++;
      $display("FAIL wr_then_rd obs=%b exp=%b", obs_out, exp_out);
    end
    step(0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_starvation();
    int k = 0;
    bit got = 0;
    mem[7] = 2'b01;
    shadow[7] = 2'b01;
    while (!got && k < 40) begin
      k++;
      step(1, AW'($urandom_range(0, 99)), 1, 0, 7, 0);
      got = obs_gnt;
      n_chk++;
      if (obs_ram !== exp_ram || obs_out !== exp_out) begin
        n_fail++;
        $display("FAIL starve_cyc%0d ram=%h/%h out=%b/%b",
          k, obs_ram, exp_ram, obs_out, exp_out);
      end
    end
    n_chk++;
    if (!got || k != SM + 1) begin
      n_fail++;
      $display("FAIL starve_grant_cycle obs=%0d exp=%0d", k, SM + 1);
    end
    step(1, AW'($urandom_range(0, 99)), 0, 0, 0, 0);
    n_chk++;
    if ({game_rvalid, game_rdata, disp_miss} !== 4'b1011 ||
        disp_rdata !== last_good_at_force(obs_out)) begin
      n_fail++;
      $display("FAIL starve_rdata obs=%b exp=%b", obs_out, exp_out);
    end
    step(0, 0, 0, 0, 0, 0);
    n_chk++;
    if (obs_out !== exp_out) begin
      n_fail++;
      $display("FAIL starve_tail obs=%b exp=%b", obs_out, exp_out);
    end
  endtask

  // Held value the model expects on a pre-empted display read.
  function automatic logic [DW-1:0] last_good_at_force(
      input logic [6:0] o);
    return (o == o) ? exp_dd : 2'bxx;
  endfunction

  task automatic test_stream();
    int pulses = 0;
    for (int a = 0; a < 102; a++) begin
      if (a < 100) step(1, AW'(a), 0, 0, 0, 0);
      else step(0, 0, 0, 0, 0, 0);
      if (disp_rvalid) pulses++;
      n_chk++;
      if (obs_out !== exp_out) begin
        n_fail++;
        $display("FAIL stream_%0d obs=%b exp=%b", a, obs_out, exp_out);
      end
    end
    n_chk++;
    if (pulses != 100) begin
      n_fail++;
      $display("FAIL stream_pulses obs=%0d exp=100", pulses);
    end
  endtask

  task automatic test_random();
    logic          hold = 0;
    logic          gw = 0;
    logic [AW-1:0] ga = 0;
    logic [DW-1:0] gd = 0;
    for (int i = 0; i < 400; i++) begin
      if (!hold && $urandom_range(0, 2) == 0) begin
        hold = 1;
        gw = 1'($urandom);
        ga = AW'($urandom_range(0, 99));
        gd = DW'($urandom);
      end
      step($urandom_range(0, 9) < 8, AW'($urandom_range(0, 99)),
           hold, gw, ga, gd);
      n_chk++;
      if (obs_ram !== exp_ram || obs_out !== exp_out) begin
        n_fail++;
        $display("FAIL random_%0d ram=%h/%h out=%b/%b",
          i, obs_ram, exp_ram, obs_out, exp_out);
      end
      if (obs_gnt) hold = 0;
      else if ($urandom_range(0, 15) == 0) hold = 0;
    end
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_reset_inflight();
    step(0, 0, 1, 0, 9, 0);
    @(negedge clk);
    rst_n = 1'b0;
    disp_req = 0;
    game_req = 0;
    #1;
    n_chk++;
    if ({disp_rvalid, disp_rdata, disp_miss, game_rvalid,
         game_rdata} !== 7'd0) begin
      n_fail++;
      $display("FAIL reset_inflight obs=%b exp=0",
        {disp_rvalid, disp_rdata, disp_miss, game_rvalid, game_rdata});
    end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0, 0, 0);
      n_chk++;
      if (obs_out !== 7'd0 || obs_ram !== 12'd0) begin
        n_fail++;
        $display("FAIL post_reset_%0d obs=%b exp=0", i, obs_out);
      end
    end
  endtask

`ifdef BOARD_ARB_STATS_EN
  task automatic test_stats();
    stats_clr = 1;
    step(0, 0, 0, 0, 0, 0);
    stats_clr = 0;
    m_stall = 0;
    m_force = 0;
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < 40; k++) begin
        step(1, AW'($urandom_range(0, 99)), 1, 0, 7, 0);
        if (obs_gnt) break;
      end
      step(0, 0, 0, 0, 0, 0);
    end
    n_chk++;
    if (stall_cnt !== 16'd48 || force_cnt !== 16'd3 ||
        m_stall != 48 || m_force != 3) begin
      n_fail++;
      $display("FAIL stats_count obs=%0d/%0d exp=48/3",
        stall_cnt, force_cnt);
    end
    stats_clr = 1;
    step(0, 0, 1, 0, 7, 0);
    stats_clr = 0;
    n_chk++;
    if (stall_cnt !== 16'd0 || force_cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL stats_clear obs=%0d/%0d exp=0/0",
        stall_cnt, force_cnt);
    end
    step(0, 0, 0, 0, 0, 0);
  endtask
`endif

  initial begin
    m_stall = 0;
    m_force = 0;
    for (int i = 0; i < 128; i++) begin
      mem[i] = DW'($urandom);
      shadow[i] = mem[i];
    end
    test_reset();
    test_single_read();
    test_write_then_read();
    test_starvation();
    test_stream();
    test_random();
`ifdef BOARD_ARB_STATS_EN
    test_stats();
`endif
    test_reset_inflight();
    $display("End of test - %0d assertions evaluated, %0d failures",
      n_chk, n_fail);
    $finish;
  end

endmodule
